// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and data-memory wait
// sequencing, plus combinational ALU operand forwarding selects.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT_MAX = 255,
  parameter logic [1:0]  LOAD_CODE   = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic [1:0]  ex_mem_to_reg,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_en,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  state,
  output logic [15:0] stall_count,
  output logic        mem_timeout
);

  localparam int unsigned REG_W   = 5;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STALL_W = 16;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FLUSH      = 2'b10,
    MEM_WAIT   = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]   w_wait_cnt_inc;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_mem_timeout;
  logic               w_mem_wait;
  logic               w_load_use;
  logic               w_timeout;

  // Producer-to-consumer forward select; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                         input logic [REG_W-1:0] m_rd, input logic m_we,
                                         input logic [REG_W-1:0] w_rd, input logic w_we);
    if (m_we && (m_rd != '0) && (m_rd == rs))      return 2'b10;
    else if (w_we && (w_rd != '0) && (w_rd == rs)) return 2'b01;
    else                                           return 2'b00;
  endfunction

  assign w_mem_wait     = mem_req & ~mem_ready;
  assign w_load_use     = ex_reg_write & (ex_mem_to_reg == LOAD_CODE) & (ex_rd != '0) &
                          ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign w_wait_cnt_inc = r_wait_cnt + CNT_W'(1);
  assign w_timeout      = (r_state == MEM_WAIT) & w_mem_wait &
                          (w_wait_cnt_inc == CNT_W'(TIMEOUT_MAX));

  assign fwd_a = rst ? 2'b00 : fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  assign fwd_b = rst ? 2'b00 : fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

  assign state       = r_state;
  assign stall_count = r_stall_cnt;
  assign mem_timeout = r_mem_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next;
  end

  // Next state and stage controls; event priority is mem wait, branch, load-use.
  always_comb begin
    w_next      = RUN;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    ex_mem_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      ex_mem_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (r_state)
        MEM_WAIT: begin
          if (w_mem_wait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            ex_mem_en = 1'b0;
            if (w_timeout) id_ex_flush = 1'b1;
            else           w_next      = MEM_WAIT;
          end
        end
        default: begin
          if (w_mem_wait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            ex_mem_en = 1'b0;
            w_next    = MEM_WAIT;
          end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_next      = FLUSH;
          end else if (r_state == FLUSH) begin
            // Second bubble for the instruction that was in ID at branch resolve.
            id_ex_flush = 1'b1;
          end else if (w_load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            w_next      = LOAD_STALL;
          end
        end
      endcase
    end
  end

  // Wait-cycle counter, saturating stall counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_stall_cnt   <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == MEM_WAIT) ? w_wait_cnt_inc : '0;
      if (!pc_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + STALL_W'(1);
      if (w_timeout) r_mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-cycle stimulus pushes the
// expected outputs into a queue that a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic [1:0] ex_mem_to_reg;
    logic [4:0] mem_rd;
    logic       mem_reg_write;
    logic [4:0] wb_rd;
    logic       wb_reg_write;
    logic       br;
    logic       mem_req;
    logic       mem_ready;
  } stim_t;

  // ctl = {pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_flush}
  typedef struct packed {
    logic [1:0]  st;
    logic [4:0]  ctl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        to;
    logic [15:0] sc;
  } exp_t;

  localparam logic [4:0] C_NORM = 5'b11100;
  localparam logic [4:0] C_RST  = 5'b00011;
  localparam logic [4:0] C_HOLD = 5'b00000;
  localparam logic [4:0] C_LU   = 5'b00101;
  localparam logic [4:0] C_BR   = 5'b11111;
  localparam logic [4:0] C_FL   = 5'b11101;
  localparam logic [4:0] C_TO   = 5'b00001;

  logic        clk;
  stim_t       s_drv;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_timeout;
  logic [1:0]  fwd_a, fwd_b, state;
  logic [15:0] stall_count;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;

  pipeline_hazard_ctrl #(.TIMEOUT_MAX(4), .LOAD_CODE(2'b01)) dut (
    .clk(clk), .rst(s_drv.rst),
    .id_rs1(s_drv.id_rs1), .id_rs2(s_drv.id_rs2),
    .ex_rs1(s_drv.ex_rs1), .ex_rs2(s_drv.ex_rs2),
    .ex_rd(s_drv.ex_rd), .ex_reg_write(s_drv.ex_reg_write), .ex_mem_to_reg(s_drv.ex_mem_to_reg),
    .mem_rd(s_drv.mem_rd), .mem_reg_write(s_drv.mem_reg_write),
    .wb_rd(s_drv.wb_rd), .wb_reg_write(s_drv.wb_reg_write),
    .ex_branch_taken(s_drv.br), .mem_req(s_drv.mem_req), .mem_ready(s_drv.mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .stall_count(stall_count), .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] st, input logic [4:0] ctl,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic to, input logic [15:0] sc);
    exp_t e;
    e.st = st; e.ctl = ctl; e.fa = fa; e.fb = fb; e.to = to; e.sc = sc;
    return e;
  endfunction

  task automatic apply(input stim_t s, input exp_t e, input string nm);
    @(posedge clk);
    #1;
    s_drv = s;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {state, {pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_flush},
            fwd_a, fwd_b, mem_timeout, stall_count};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got st=%b ctl=%b fa=%b fb=%b to=%b sc=%0d, want st=%b ctl=%b fa=%b fb=%b to=%b sc=%0d",
                 nm, a.st, a.ctl, a.fa, a.fb, a.to, a.sc, e.st, e.ctl, e.fa, e.fb, e.to, e.sc);
      end
    end
  end

  initial begin
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    s_drv = s;

    // Reset forces controls and masks a live forwarding match.
    s.mem_rd = 5'd7; s.mem_reg_write = 1'b1; s.ex_rs1 = 5'd7;
    apply(s, mk(2'b00, C_RST, 2'b00, 2'b00, 1'b0, 16'd0), "reset_outputs");
    s = '0;
    apply(s, mk(2'b00, C_NORM, 2'b00, 2'b00, 1'b0, 16'd0), "idle_after_reset");

    // Load-use on rs2.
    s.ex_reg_write = 1'b1; s.ex_mem_to_reg = 2'b01; s.ex_rd = 5'd5; s.id_rs2 = 5'd5;
    apply(s, mk(2'b00, C_LU, 2'b00, 2'b00, 1'b0, 16'd0), "load_use_detect");
    s = '0;
    apply(s, mk(2'b01, C_NORM, 2'b00, 2'b00, 1'b0, 16'd1), "load_stall_state");
    apply(s, mk(2'b00, C_NORM, 2'b00, 2'b00, 1'b0, 16'd1), "load_stall_return");
    s.ex_reg_write = 1'b1; s.ex_mem_to_reg = 2'b01; s.ex_rd = 5'd0; s.id_rs1 = 5'd0;
    apply(s, mk(2'b00, C_NORM, 2'b00, 2'b00, 1'b0, 16'd1), "load_use_x0");
    s.ex_mem_to_reg = 2'b00; s.ex_rd = 5'd5; s.id_rs1 = 5'd5;
    apply(s, mk(2'b00, C_NORM, 2'b00, 2'b00, 1'b0, 16'd1), "non_load_no_stall");
    s = '0;

    // Branch flush, then back-to-back branches restarting FLUSH.
    s.br = 1'b1;
    apply(s, mk(2'b00, C_BR, 2'b00, 2'b00, 1'b0, 16'd1), "branch_cycle0");
    s = '0;
    apply(s, mk(2'b10, C_FL, 2'b00, 2'b00, 1'b0, 16'd1), "branch_cycle1");
    apply(s, mk(2'b00, C_NORM, 2'b00, 2'b00, 1'b0, 16'd1), "branch_cycle2");
    s.br = 1'b1;
    apply(s, mk(2'b00, C_BR, 2'b00, 2'b00, 1'b0, 16'd1), "branch_a");
    apply(s, mk(2'b10, C_BR, 2'b00, 2'b00, 1'b0, 16'd1), "branch_restart");
    s = '0;
    apply(s, mk(2'b10, C_FL, 2'b00, 2'b00, 1'b0, 16'd1), "branch_restart_flush");
    apply(s, mk(2'b00, C_NORM, 2'b00, 2'b00, 1'b0, 16'd1), "branch_restart_done");

    // Memory wait for three cycles then ready.
    s.mem_req = 1'b1;
    apply(s, mk(2'b00, C_HOLD, 2'b00, 2'b00, 1'b0, 16'd1), "memwait_entry");
    apply(s, mk(2'b11, C_HOLD, 2'b00, 2'b00, 1'b0, 16'd2), "memwait_hold1");
    apply(s, mk(2'b11, C_HOLD, 2'b00, 2'b00, 1'b0, 16'd3), "memwait_hold2");
    s.mem_ready = 1'b1;
    apply(s, mk(2'b11, C_NORM, 2'b00, 2'b00, 1'b0, 16'd4), "memwait_ready");
    s = '0;
    apply(s, mk(2'b00, C_NORM, 2'b00, 2'b00, 1'b0, 16'd4), "memwait_done");

    // All three events at once: mem wait wins, no flush.
    s.mem_req = 1'b1; s.br = 1'b1;
    s.ex_reg_write = 1'b1; s.ex_mem_to_reg = 2'b01; s.ex_rd = 5'd5; s.id_rs1 = 5'd5;
    apply(s, mk(2'b00, C_HOLD, 2'b00, 2'b00, 1'b0, 16'd4), "priority_memwait");
    s = '0; s.mem_req = 1'b1; s.mem_ready = 1'b1;
    apply(s, mk(2'b11, C_NORM, 2'b00, 2'b00, 1'b0, 16'd5), "priority_release");
    s = '0;
    apply(s, mk(2'b00, C_NORM, 2'b00, 2'b00, 1'b0, 16'd5), "priority_done");

    // Forwarding selects.
    s.mem_rd = 5'd7; s.wb_rd = 5'd7; s.ex_rs1 = 5'd7;
    s.mem_reg_write = 1'b1; s.wb_reg_write = 1'b1;
    apply(s, mk(2'b00, C_NORM, 2'b10, 2'b00, 1'b0, 16'd5), "fwd_mem_priority");
    s.ex_rs1 = 5'd0; s.ex_rs2 = 5'd7;
    apply(s, mk(2'b00, C_NORM, 2'b00, 2'b10, 1'b0, 16'd5), "fwd_x0_and_b");
    s.mem_rd = 5'd9; s.ex_rs1 = 5'd7; s.ex_rs2 = 5'd9;
    apply(s, mk(2'b00, C_NORM, 2'b01, 2'b10, 1'b0, 16'd5), "fwd_wb_a_mem_b");
    s.mem_reg_write = 1'b0;
    apply(s, mk(2'b00, C_NORM, 2'b01, 2'b00, 1'b0, 16'd5), "fwd_mem_we_off");

    // Timeout with TIMEOUT_MAX=4, forwarding held to show FSM independence.
    s.mem_req = 1'b1;
    apply(s, mk(2'b00, C_HOLD, 2'b01, 2'b00, 1'b0, 16'd5), "timeout_entry");
    apply(s, mk(2'b11, C_HOLD, 2'b01, 2'b00, 1'b0, 16'd6), "timeout_wait1");
    apply(s, mk(2'b11, C_HOLD, 2'b01, 2'b00, 1'b0, 16'd7), "timeout_wait2");
    apply(s, mk(2'b11, C_HOLD, 2'b01, 2'b00, 1'b0, 16'd8), "timeout_wait3");
    apply(s, mk(2'b11, C_TO, 2'b01, 2'b00, 1'b0, 16'd9), "timeout_abort");
    apply(s, mk(2'b00, C_HOLD, 2'b01, 2'b00, 1'b1, 16'd10), "timeout_flag_set");
    s = '0;
    apply(s, mk(2'b11, C_NORM, 2'b00, 2'b00, 1'b1, 16'd11), "timeout_req_drop");
    apply(s, mk(2'b00, C_NORM, 2'b00, 2'b00, 1'b1, 16'd11), "timeout_sticky");

    // Reset mid-flush and mid-wait aborts at once.
    s.br = 1'b1;
    apply(s, mk(2'b00, C_BR, 2'b00, 2'b00, 1'b1, 16'd11), "pre_reset_branch");
    s = '0; s.rst = 1'b1;
    apply(s, mk(2'b00, C_RST, 2'b00, 2'b00, 1'b0, 16'd0), "reset_mid_flush");
    s = '0;
    apply(s, mk(2'b00, C_NORM, 2'b00, 2'b00, 1'b0, 16'd0), "run_after_reset1");
    s.mem_req = 1'b1;
    apply(s, mk(2'b00, C_HOLD, 2'b00, 2'b00, 1'b0, 16'd0), "pre_reset_wait");
    apply(s, mk(2'b11, C_HOLD, 2'b00, 2'b00, 1'b0, 16'd1), "pre_reset_wait2");
    s = '0; s.rst = 1'b1;
    apply(s, mk(2'b00, C_RST, 2'b00, 2'b00, 1'b0, 16'd0), "reset_mid_wait");
    s = '0;
    apply(s, mk(2'b00, C_NORM, 2'b00, 2'b00, 1'b0, 16'd0), "run_after_reset2");

    // Drain with a bounded wait.
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
